// File: rtl/axi_rd_xbar_rr.sv
// -----------------------------------------------------------------------------
// axi_rd_xbar_rr
//   AXI4 read-channel crossbar, NM masters to NS slaves.
//   - AR: address decode on araddr[SEL_LSB+:4], one round-robin arbiter per
//     slave (IDLE/ISSUE), winner registered, payload muxed combinationally.
//   - R: combinational return routing on the master tag carried in the upper
//     MIW bits of the slave-side ID.
//   - Unmapped addresses (slave index >= NS) are answered by a single DECERR
//     engine that returns arlen+1 beats of rresp=2'b11, rdata=0.
//   - Each master may have one read outstanding; its busy flag blocks new AR.
//
// Ports (per-port fields packed, port i at [i*W +: W])
//   acr_clk, acr_rst          clock, asynchronous active-low reset
//   s_ar*  / s_arready        master-side AR channel (NM ports)
//   s_r*   / s_rready         master-side R channel (NM ports)
//   m_ar*  / m_arready        slave-side AR channel (NS ports), m_arid = {tag, id}
//   m_r*   / m_rready         slave-side R channel (NS ports)
// -----------------------------------------------------------------------------
module axi_rd_xbar_rr #(
  parameter int NM      = 5,
  parameter int NS      = 3,
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int IDW     = 8,
  parameter int MIW     = $clog2(NM),
  parameter int SEL_LSB = 28
) (
  input  logic                     acr_clk,
  input  logic                     acr_rst,
  // master-side AR
  input  logic [NM*IDW-1:0]        s_arid,
  input  logic [NM*AW-1:0]         s_araddr,
  input  logic [NM*4-1:0]          s_arlen,
  input  logic [NM*3-1:0]          s_arsize,
  input  logic [NM*2-1:0]          s_arburst,
  input  logic [NM*3-1:0]          s_arprot,
  input  logic [NM-1:0]            s_arvalid,
  output logic [NM-1:0]            s_arready,
  // master-side R
  output logic [NM*IDW-1:0]        s_rid,
  output logic [NM*DW-1:0]         s_rdata,
  output logic [NM*2-1:0]          s_rresp,
  output logic [NM-1:0]            s_rlast,
  output logic [NM-1:0]            s_rvalid,
  input  logic [NM-1:0]            s_rready,
  // slave-side AR
  output logic [NS*(IDW+MIW)-1:0]  m_arid,
  output logic [NS*AW-1:0]         m_araddr,
  output logic [NS*4-1:0]          m_arlen,
  output logic [NS*3-1:0]          m_arsize,
  output logic [NS*2-1:0]          m_arburst,
  output logic [NS*3-1:0]          m_arprot,
  output logic [NS-1:0]            m_arvalid,
  input  logic [NS-1:0]            m_arready,
  // slave-side R
  input  logic [NS*(IDW+MIW)-1:0]  m_rid,
  input  logic [NS*DW-1:0]         m_rdata,
  input  logic [NS*2-1:0]          m_rresp,
  input  logic [NS-1:0]            m_rlast,
  input  logic [NS-1:0]            m_rvalid,
  output logic [NS-1:0]            m_rready
);

  localparam int         TW  = IDW + MIW;
  localparam logic [3:0] NS4 = 4'(NS);

  typedef enum logic {ARB_IDLE, ARB_ISSUE} arb_state_e;
  typedef enum logic {DEC_IDLE, DEC_RESP}  dec_state_e;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [NM-1:0] busy_q, busy_d;
  logic [3:0]    sel    [NM];
  logic [NM-1:0] mapped;
  logic [NM-1:0] elig;

  // NOTE: every combinational output gets a value on every path (here the loop
  // covers all elements); a path that leaves a variable unassigned infers a latch.
  always_comb begin
    for (int i = 0; i < NM; i++) begin
      sel[i]    = s_araddr[i*AW + SEL_LSB +: 4];
      mapped[i] = (sel[i] < NS4);
      elig[i]   = s_arvalid[i] & ~busy_q[i];
    end
  end

  // One-hot AR acceptance per slave arbiter, OR-ed into s_arready below.
  logic [NS-1:0][NM-1:0] ar_grant;

  // ---------------------------------------------------------------------------
  // Per-slave round-robin arbiters
  // ---------------------------------------------------------------------------
  for (genvar gs = 0; gs < NS; gs++) begin : g_arb
    arb_state_e     arb_q, arb_d;
    logic [MIW-1:0] ptr_q, ptr_d;
    logic [MIW-1:0] win_q, win_d;
    logic [MIW-1:0] pick;
    logic           found;
    logic [NM-1:0]  req;

    always_comb begin
      int idx;
      idx   = 0;
      req   = '0;
      found = 1'b0;
      pick  = '0;
      arb_d = arb_q;
      win_d = win_q;
      ptr_d = ptr_q;

      for (int i = 0; i < NM; i++) begin
        req[i] = elig[i] & mapped[i] & (sel[i] == 4'(gs));
      end

      // First requester at or after ptr, wrapping; ptr+k < 2*NM so one
      // conditional subtract replaces the modulo.
      for (int k = 0; k < NM; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NM) idx = idx - NM;
        if (!found && req[idx]) begin
          found = 1'b1;
          pick  = MIW'(idx);
        end
      end

      case (arb_q)
        ARB_IDLE: begin
          if (found) begin
            win_d = pick;
            arb_d = ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (m_arready[gs]) begin
            ptr_d = (win_q == MIW'(NM - 1)) ? '0 : win_q + MIW'(1);
            arb_d = ARB_IDLE;
          end
        end
        default: arb_d = ARB_IDLE;
      endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of process ordering.
    always_ff @(posedge acr_clk or negedge acr_rst) begin
      if (!acr_rst) begin
        arb_q <= ARB_IDLE;
        ptr_q <= '0;
        win_q <= '0;
      end else begin
        arb_q <= arb_d;
        ptr_q <= ptr_d;
        win_q <= win_d;
      end
    end

    // Registered select, combinational payload: the winner holds its AR
    // stable until the handshake, so the muxed payload is stable too.
    assign m_arvalid[gs]              = (arb_q == ARB_ISSUE);
    assign m_arid[gs*TW +: TW]        = {win_q, s_arid[int'(win_q)*IDW +: IDW]};
    assign m_araddr[gs*AW +: AW]      = s_araddr[int'(win_q)*AW +: AW];
    assign m_arlen[gs*4 +: 4]         = s_arlen[int'(win_q)*4 +: 4];
    assign m_arsize[gs*3 +: 3]        = s_arsize[int'(win_q)*3 +: 3];
    assign m_arburst[gs*2 +: 2]       = s_arburst[int'(win_q)*2 +: 2];
    assign m_arprot[gs*3 +: 3]        = s_arprot[int'(win_q)*3 +: 3];
    assign ar_grant[gs] = (arb_q == ARB_ISSUE && m_arready[gs]) ?
                          (NM'(1) << win_q) : '0;
  end

  // ---------------------------------------------------------------------------
  // DECERR responder for unmapped addresses
  // ---------------------------------------------------------------------------
  dec_state_e     dec_q, dec_d;
  logic [IDW-1:0] dec_id_q, dec_id_d;
  logic [MIW-1:0] dec_mst_q, dec_mst_d;
  logic [3:0]     dec_cnt_q, dec_cnt_d;
  logic [MIW-1:0] dec_pick;
  logic           dec_found;
  logic [NM-1:0]  dec_grant;

  always_comb begin
    dec_found = 1'b0;
    dec_pick  = '0;
    dec_d     = dec_q;
    dec_id_d  = dec_id_q;
    dec_mst_d = dec_mst_q;
    dec_cnt_d = dec_cnt_q;
    dec_grant = '0;

    // Lowest-index eligible unmapped request.
    for (int i = 0; i < NM; i++) begin
      if (!dec_found && elig[i] && !mapped[i]) begin
        dec_found = 1'b1;
        dec_pick  = MIW'(i);
      end
    end

    case (dec_q)
      DEC_IDLE: begin
        if (dec_found) begin
          dec_grant = NM'(1) << dec_pick;
          dec_id_d  = s_arid[int'(dec_pick)*IDW +: IDW];
          dec_mst_d = dec_pick;
          dec_cnt_d = s_arlen[int'(dec_pick)*4 +: 4];
          dec_d     = DEC_RESP;
        end
      end
      DEC_RESP: begin
        if (s_rready[dec_mst_q]) begin
          if (dec_cnt_q == 4'd0) dec_d = DEC_IDLE;
          else                   dec_cnt_d = dec_cnt_q - 4'd1;
        end
      end
      default: dec_d = DEC_IDLE;
    endcase
  end

  always_ff @(posedge acr_clk or negedge acr_rst) begin
    if (!acr_rst) begin
      dec_q     <= DEC_IDLE;
      dec_id_q  <= '0;
      dec_mst_q <= '0;
      dec_cnt_q <= '0;
    end else begin
      dec_q     <= dec_d;
      dec_id_q  <= dec_id_d;
      dec_mst_q <= dec_mst_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // AR acceptance towards masters
  // ---------------------------------------------------------------------------
  logic [NM-1:0] ar_acc;

  // Gated with reset so no ready/valid leaks out combinationally while the
  // fabric is held in reset.
  always_comb begin
    ar_acc = dec_grant;
    for (int s = 0; s < NS; s++) begin
      ar_acc = ar_acc | ar_grant[s];
    end
    s_arready = acr_rst ? ar_acc : '0;
  end

  // ---------------------------------------------------------------------------
  // R return routing
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [MIW-1:0] tag;
    tag      = '0;
    s_rvalid = '0;
    s_rid    = '0;
    s_rdata  = '0;
    s_rresp  = '0;
    s_rlast  = '0;
    m_rready = '0;

    // One outstanding read per master means at most one source per master.
    for (int s = 0; s < NS; s++) begin
      tag = m_rid[s*TW + IDW +: MIW];
      if (int'(tag) >= NM) begin
        m_rready[s] = 1'b1;   // tag matches no master: sink and drop the beat
      end else begin
        m_rready[s] = s_rready[tag];
        if (m_rvalid[s]) begin
          s_rvalid[tag]                = 1'b1;
          s_rid[int'(tag)*IDW +: IDW]  = m_rid[s*TW +: IDW];
          s_rdata[int'(tag)*DW +: DW]  = m_rdata[s*DW +: DW];
          s_rresp[int'(tag)*2 +: 2]    = m_rresp[s*2 +: 2];
          s_rlast[tag]                 = m_rlast[s];
        end
      end
    end

    if (dec_q == DEC_RESP) begin
      s_rvalid[dec_mst_q]               = 1'b1;
      s_rid[int'(dec_mst_q)*IDW +: IDW] = dec_id_q;
      s_rdata[int'(dec_mst_q)*DW +: DW] = '0;
      s_rresp[int'(dec_mst_q)*2 +: 2]   = 2'b11;
      s_rlast[dec_mst_q]                = (dec_cnt_q == 4'd0);
    end

    if (!acr_rst) begin
      s_rvalid = '0;
      m_rready = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-master outstanding flag
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NM; i++) begin
      if (s_arvalid[i] && s_arready[i])                   busy_d[i] = 1'b1;
      else if (s_rvalid[i] && s_rready[i] && s_rlast[i])  busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge acr_clk or negedge acr_rst) begin
    if (!acr_rst) busy_q <= '0;
    else          busy_q <= busy_d;
  end

endmodule

// File: tb/tb_axi_rd_xbar_rr.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_xbar_rr
//   Self-checking bench for axi_rd_xbar_rr (5 masters, 3 slaves). The bench
//   plays every master and slave; each R beat it offers on a slave port (or
//   expects from DECERR) is pushed to a scoreboard and popped by a monitor when
//   the matching master-side handshake appears.
// -----------------------------------------------------------------------------
module tb_axi_rd_xbar_rr;

  localparam int NM  = 5;
  localparam int NS  = 3;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 8;
  localparam int MIW = 3;
  localparam int TW  = IDW + MIW;

  typedef struct {
    int             mst;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  logic clk;
  logic rst_n;

  logic [NM*IDW-1:0] s_arid;
  logic [NM*AW-1:0]  s_araddr;
  logic [NM*4-1:0]   s_arlen;
  logic [NM*3-1:0]   s_arsize;
  logic [NM*2-1:0]   s_arburst;
  logic [NM*3-1:0]   s_arprot;
  logic [NM-1:0]     s_arvalid;
  logic [NM-1:0]     s_arready;
  logic [NM*IDW-1:0] s_rid;
  logic [NM*DW-1:0]  s_rdata;
  logic [NM*2-1:0]   s_rresp;
  logic [NM-1:0]     s_rlast;
  logic [NM-1:0]     s_rvalid;
  logic [NM-1:0]     s_rready;
  logic [NS*TW-1:0]  m_arid;
  logic [NS*AW-1:0]  m_araddr;
  logic [NS*4-1:0]   m_arlen;
  logic [NS*3-1:0]   m_arsize;
  logic [NS*2-1:0]   m_arburst;
  logic [NS*3-1:0]   m_arprot;
  logic [NS-1:0]     m_arvalid;
  logic [NS-1:0]     m_arready;
  logic [NS*TW-1:0]  m_rid;
  logic [NS*DW-1:0]  m_rdata;
  logic [NS*2-1:0]   m_rresp;
  logic [NS-1:0]     m_rlast;
  logic [NS-1:0]     m_rvalid;
  logic [NS-1:0]     m_rready;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  axi_rd_xbar_rr #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .IDW(IDW), .MIW(MIW), .SEL_LSB(28)
  ) dut (
    .acr_clk   (clk),
    .acr_rst   (rst_n),
    .s_arid    (s_arid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_arprot  (s_arprot),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rid     (s_rid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_arid    (m_arid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard consumer: every master-side R handshake must match the oldest
  // expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      for (int i = 0; i < NM; i++) begin
        if (s_rvalid[i] && s_rready[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rbeat_unexpected m%0d id=%h data=%h", i,
                     s_rid[i*IDW +: IDW], s_rdata[i*DW +: DW]);
          end else begin
            e = exp_q.pop_front();
            if (e.mst !== i || s_rid[i*IDW +: IDW] !== e.id ||
                s_rdata[i*DW +: DW] !== e.data || s_rresp[i*2 +: 2] !== e.resp ||
                s_rlast[i] !== e.last) begin
              errors++;
              $display("FAIL rbeat got m%0d id=%h data=%h resp=%b last=%b want m%0d id=%h data=%h resp=%b last=%b",
                       i, s_rid[i*IDW +: IDW], s_rdata[i*DW +: DW], s_rresp[i*2 +: 2],
                       s_rlast[i], e.mst, e.id, e.data, e.resp, e.last);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all drive at posedge+1 and return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic issue_ar(input int m, input logic [AW-1:0] addr,
                          input logic [3:0] len, input logic [IDW-1:0] id);
    s_araddr[m*AW +: AW]  = addr;
    s_arlen[m*4 +: 4]     = len;
    s_arid[m*IDW +: IDW]  = id;
    s_arsize[m*3 +: 3]    = 3'd3;
    s_arburst[m*2 +: 2]   = 2'b01;
    s_arprot[m*3 +: 3]    = 3'd0;
    s_arvalid[m]          = 1'b1;
  endtask

  task automatic wait_s_ar(input int m);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (s_arready[m]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    s_arvalid[m] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ar_accept_timeout m%0d got s_arready=0 want 1", m);
    end
  endtask

  // Slave s offers one R beat tagged for master tag; s_rready[tag] is held
  // low for 'stall' cycles first.
  task automatic send_beat(input int s, input int tag, input logic [IDW-1:0] id,
                           input logic [DW-1:0] data, input logic last, input int stall);
    beat_t b;
    bit    ok;
    m_rid[s*TW +: TW]   = {MIW'(tag), id};
    m_rdata[s*DW +: DW] = data;
    m_rresp[s*2 +: 2]   = 2'b00;
    m_rlast[s]          = last;
    m_rvalid[s]         = 1'b1;
    if (tag < NM) begin
      b.mst = tag; b.id = id; b.data = data; b.resp = 2'b00; b.last = last;
      exp_q.push_back(b);
    end
    if (stall > 0) begin
      s_rready[tag] = 1'b0;
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        checks++;
        if (m_rready[s] !== 1'b0 || s_rvalid[tag] !== 1'b1 ||
            s_rdata[tag*DW +: DW] !== data) begin
          errors++;
          $display("FAIL stall_hold c%0d got m_rready=%b s_rvalid=%b data=%h want 0 1 %h",
                   c, m_rready[s], s_rvalid[tag], s_rdata[tag*DW +: DW], data);
        end
        @(posedge clk); #1;
      end
      s_rready[tag] = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_rready[s]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    m_rvalid[s] = 1'b0;
    m_rlast[s]  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL r_handshake_timeout slave%0d got m_rready=0 want 1", s);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    s_arid    = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_arburst = '0; s_arprot = '0; s_arvalid = '0;
    s_rready  = '1;
    m_arready = '1;
    m_rid     = '0; m_rdata = '0; m_rresp = '0; m_rlast = '0; m_rvalid = '0;
    // Live requests during reset must not leak through.
    issue_ar(3, 32'hF000_0000, 4'd0, 8'h01);
    m_rid[0 +: TW] = {3'd1, 8'h00};
    m_rvalid[0]    = 1'b1;
    #3;
    checks++;
    if (m_arvalid !== '0 || s_arready !== '0) begin
      errors++;
      $display("FAIL reset_ar got m_arvalid=%b s_arready=%b want 0 0", m_arvalid, s_arready);
    end
    checks++;
    if (s_rvalid !== '0 || m_rready !== '0) begin
      errors++;
      $display("FAIL reset_r got s_rvalid=%b m_rready=%b want 0 0", s_rvalid, m_rready);
    end
    s_arvalid = '0;
    m_rvalid  = '0;
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ar_route();
    issue_ar(0, 32'h1000_0040, 4'd3, 8'h5A);
    @(negedge clk);
    checks++;
    if (m_arvalid !== 3'b000) begin
      errors++;
      $display("FAIL ar_latency_early got m_arvalid=%b want 000", m_arvalid);
    end
    @(negedge clk);
    checks++;
    if (m_arvalid !== 3'b010 || m_arid[1*TW +: TW] !== {3'd0, 8'h5A} ||
        m_araddr[1*AW +: AW] !== 32'h1000_0040 || m_arlen[1*4 +: 4] !== 4'd3 ||
        m_arsize[1*3 +: 3] !== 3'd3 || s_arready !== 5'b00001) begin
      errors++;
      $display("FAIL ar_route got valid=%b id=%h addr=%h len=%h sz=%h s_arready=%b want 010 05a 10000040 3 3 00001",
               m_arvalid, m_arid[1*TW +: TW], m_araddr[1*AW +: AW], m_arlen[1*4 +: 4],
               m_arsize[1*3 +: 3], s_arready);
    end
    @(posedge clk); #1;
    s_arvalid[0] = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(1, 0, 8'h5A, 64'hA000 + 64'(b), b == 3, 0);
    // Last beat cleared busy: a fresh AR from M0 reaches the slave after one cycle.
    issue_ar(0, 32'h1000_0000, 4'd0, 8'h5B);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_arvalid[1] !== 1'b1 || s_arready[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_clear got m_arvalid1=%b s_arready0=%b want 1 1", m_arvalid[1], s_arready[0]);
    end
    @(posedge clk); #1;
    s_arvalid[0] = 1'b0;
    send_beat(1, 0, 8'h5B, 64'hB000, 1'b1, 0);
  endtask

  task automatic rr_round(input int rnd);
    int got[3];
    int cyc[3];
    int n;
    int want[3];
    want[0] = 0; want[1] = 2; want[2] = 4;
    n = 0;
    issue_ar(0, 32'h0000_0100, 4'd0, 8'h30);
    issue_ar(2, 32'h0000_0200, 4'd0, 8'h32);
    issue_ar(4, 32'h0000_0300, 4'd0, 8'h34);
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (m_arvalid[0] && m_arready[0]) begin
        got[n] = int'(m_arid[IDW +: MIW]);
        cyc[n] = c;
        checks++;
        if (got[n] >= NM || s_arready !== (5'b00001 << got[n])) begin
          errors++;
          $display("FAIL rr_ready r%0d got s_arready=%b tag=%0d", rnd, s_arready, got[n]);
        end
        @(posedge clk); #1;
        if (got[n] < NM) s_arvalid[got[n]] = 1'b0;
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL rr_timeout r%0d got %0d grants want 3", rnd, n);
      s_arvalid = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== want[k] || cyc[k] !== 1 + 2*k) begin
          errors++;
          $display("FAIL rr_order r%0d k%0d got m%0d@%0d want m%0d@%0d",
                   rnd, k, got[k], cyc[k], want[k], 1 + 2*k);
        end
      end
    end
    @(posedge clk); #1;
    send_beat(0, 0, 8'h30, 64'hC0, 1'b1, 0);
    send_beat(0, 2, 8'h32, 64'hC2, 1'b1, 0);
    send_beat(0, 4, 8'h34, 64'hC4, 1'b1, 0);
  endtask

  task automatic test_round_robin();
    rr_round(0);
    rr_round(1);
  endtask

  task automatic test_decerr();
    beat_t b;
    bit    bad_ar;
    bad_ar = 1'b0;
    issue_ar(3, 32'hF000_0000, 4'd2, 8'h11);
    for (int k = 0; k < 3; k++) begin
      b.mst = 3; b.id = 8'h11; b.data = '0; b.resp = 2'b11; b.last = (k == 2);
      exp_q.push_back(b);
    end
    @(negedge clk);
    checks++;
    if (s_arready !== 5'b01000 || m_arvalid !== 3'b000) begin
      errors++;
      $display("FAIL decerr_accept got s_arready=%b m_arvalid=%b want 01000 000", s_arready, m_arvalid);
    end
    @(posedge clk); #1;
    s_arvalid[3] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m_arvalid !== 3'b000) bad_ar = 1'b1;
      if (exp_q.size() == 0) break;
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || bad_ar) begin
      errors++;
      $display("FAIL decerr_done got pending=%0d stray_ar=%b want 0 0", exp_q.size(), bad_ar);
    end
  endtask

  task automatic test_outstanding();
    issue_ar(1, 32'h2000_0000, 4'd1, 8'h21);
    wait_s_ar(1);
    send_beat(2, 1, 8'h21, 64'hD0, 1'b0, 0);
    issue_ar(1, 32'h2000_0080, 4'd0, 8'h22);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (s_arready[1] !== 1'b0 || m_arvalid[2] !== 1'b0) begin
        errors++;
        $display("FAIL busy_block c%0d got s_arready1=%b m_arvalid2=%b want 0 0",
                 c, s_arready[1], m_arvalid[2]);
      end
    end
    @(posedge clk); #1;
    send_beat(2, 1, 8'h21, 64'hD1, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (s_arready[1] !== 1'b0 || m_arvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL busy_release_early got s_arready1=%b m_arvalid2=%b want 0 0", s_arready[1], m_arvalid[2]);
    end
    @(negedge clk);
    checks++;
    if (s_arready[1] !== 1'b1 || m_arvalid[2] !== 1'b1 || m_arid[2*TW +: TW] !== {3'd1, 8'h22}) begin
      errors++;
      $display("FAIL busy_release got s_arready1=%b m_arvalid2=%b id=%h want 1 1 122",
               s_arready[1], m_arvalid[2], m_arid[2*TW +: TW]);
    end
    @(posedge clk); #1;
    s_arvalid[1] = 1'b0;
    send_beat(2, 1, 8'h22, 64'hD2, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    issue_ar(0, 32'h0000_0200, 4'd7, 8'h77);
    wait_s_ar(0);
    for (int b = 0; b < 8; b++) send_beat(0, 0, 8'h77, 64'h5500 + 64'(b), b == 7, (b == 3) ? 5 : 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_bad_tag();
    m_rid[0 +: TW] = {3'd5, 8'h00};
    m_rdata[0 +: DW] = 64'hDEAD;
    m_rlast[0] = 1'b1;
    m_rvalid[0] = 1'b1;
    s_rready = '0;
    @(negedge clk);
    checks++;
    if (m_rready[0] !== 1'b1 || s_rvalid !== '0) begin
      errors++;
      $display("FAIL bad_tag got m_rready0=%b s_rvalid=%b want 1 00000", m_rready[0], s_rvalid);
    end
    @(posedge clk); #1;
    m_rvalid[0] = 1'b0;
    m_rlast[0]  = 1'b0;
    s_rready    = '1;
  endtask

  task automatic test_reset_mid();
    m_arready[2] = 1'b0;
    issue_ar(2, 32'h2000_0000, 4'd0, 8'h66);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_arvalid[2] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_issue got m_arvalid2=%b want 1", m_arvalid[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_arvalid !== 3'b000 || s_arready !== '0) begin
      errors++;
      $display("FAIL reset_mid_drop got m_arvalid=%b s_arready=%b want 000 00000", m_arvalid, s_arready);
    end
    s_arvalid    = '0;
    m_arready[2] = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue_ar(2, 32'h2000_0040, 4'd0, 8'h67);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_arvalid !== 3'b100 || m_arid[2*TW +: TW] !== {3'd2, 8'h67} || s_arready !== 5'b00100) begin
      errors++;
      $display("FAIL reset_mid_after got m_arvalid=%b id=%h s_arready=%b want 100 267 00100",
               m_arvalid, m_arid[2*TW +: TW], s_arready);
    end
    @(posedge clk); #1;
    s_arvalid[2] = 1'b0;
    send_beat(2, 2, 8'h67, 64'hE0, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_ar_route();
    test_round_robin();
    test_decerr();
    test_outstanding();
    test_backpressure();
    test_bad_tag();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
